// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared bus types and defaults for the Z80/host RAM arbiter.
package z80_bus_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_CPU, ST_H_SETUP, ST_H_STROBE, ST_H_HOLD} state_t;
    localparam int ADDR_W_DEF        = 16;
    localparam int ACCESS_CYCLES_DEF = 3;
endpackage

// File: rtl/z80_mem_arbiter.sv
// z80_mem_arbiter: shares one async SRAM between the Z80 (absolute priority) and a host loader.
module z80_mem_arbiter
    import z80_bus_pkg::*;
#(
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
    parameter int ADDR_W        = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mreq_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,
    output logic              ram_cs_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [7:0]        ram_rdata,
    output logic              cpu_owner
);
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              hwe_q, hwe_d;
    logic              cs_q, cs_d, oe_q, oe_d, we_q, we_d, woe_q, woe_d;
    logic              ack_q, ack_d, own_q, own_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d, rdata_q, rdata_d;
    logic              cpu_active;

    assign cpu_active = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);

    // Next values are computed for the state being entered, so every output is a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hwe_d   = hwe_q;
        cs_d    = cs_q;
        oe_d    = oe_q;
        we_d    = we_q;
        woe_d   = woe_q;
        own_d   = own_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_active) begin
                    state_d = ST_CPU;
                    cs_d    = 1'b0;
                    addr_d  = cpu_addr;
                    oe_d    = cpu_rd_n;
                    we_d    = cpu_wr_n;
                end else if (host_req) begin
                    state_d = ST_H_SETUP;
                    cs_d    = 1'b0;
                    addr_d  = host_addr;
                    wdata_d = host_wdata;
                    hwe_d   = host_we;
                    woe_d   = host_we;
                    own_d   = 1'b0;
                    cnt_d   = 4'(ACCESS_CYCLES);
                end
            end
            ST_CPU: begin
                state_d = (cpu_rd_n && cpu_wr_n) ? ST_IDLE : ST_CPU;
                cs_d    = cpu_rd_n && cpu_wr_n;
                addr_d  = cpu_addr;
                oe_d    = cpu_rd_n;
                we_d    = cpu_wr_n;
            end
            ST_H_SETUP: begin
                state_d = ST_H_STROBE;
                oe_d    = hwe_q;
                we_d    = !hwe_q;
            end
            ST_H_STROBE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_H_HOLD;
                    oe_d    = 1'b1;
                    we_d    = 1'b1;
                    ack_d   = 1'b1;
                    rdata_d = hwe_q ? rdata_q : ram_rdata;
                end
            end
            ST_H_HOLD: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                woe_d   = 1'b0;
                own_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                oe_d    = 1'b1;
                we_d    = 1'b1;
                woe_d   = 1'b0;
                own_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hwe_q   <= 1'b0;
            cs_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            woe_q   <= 1'b0;
            own_q   <= 1'b1;
            ack_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hwe_q   <= hwe_d;
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            woe_q   <= woe_d;
            own_q   <= own_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign host_ack     = ack_q;
    assign host_rdata   = rdata_q;
    assign ram_cs_n     = cs_q;
    assign ram_oe_n     = oe_q;
    assign ram_we_n     = we_q;
    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;
    assign ram_wdata_oe = woe_q;
    assign cpu_owner    = own_q;
endmodule
